// File: rtl/count_ones_sched.sv
// count_ones_sched: round-robin sharing of one multi-cycle count-ones engine among NUM_REQ requesters
module count_ones_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [CNT_W-1:0]          result_o,
  output logic                      timeout_err_o,
  output logic                      busy_o,
  output logic                      eng_start_o,
  output logic [DATA_W-1:0]         eng_data_o,
  input  logic [CNT_W-1:0]          eng_cnt_i,
  input  logic                      eng_rdy_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, win_q, win_d, win;
  logic [WW-1:0]       wd_q, wd_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic [CNT_W-1:0]    result_q, result_d;
  logic                terr_q, terr_d, busy_q, busy_d, start_q, start_d, hit;
  logic [DATA_W-1:0]   data_q, data_d;
  // Scan from the farthest candidate back to ptr so the first one in round-robin order wins.
  always_comb begin
    win = ptr_q;
    hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (req_i[j]) begin
        win = PW'(j);
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    wd_d     = wd_q;
    grant_d  = grant_q;
    done_d   = done_q;
    result_d = result_q;
    terr_d   = terr_q;
    busy_d   = busy_q;
    start_d  = start_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: if (hit) begin
        state_d = S_LAUNCH;
        win_d   = win;
        grant_d = NUM_REQ'(1) << win;
        data_d  = req_data_i[win*DATA_W +: DATA_W];
        start_d = 1'b1;
        busy_d  = 1'b1;
      end
      // eng_rdy is not trusted here: the engine may still show the previous completion.
      S_LAUNCH: begin
        state_d = S_WAIT;
        start_d = 1'b0;
        wd_d    = '0;
      end
      S_WAIT: if (eng_rdy_i) begin
        state_d  = S_DONE;
        result_d = eng_cnt_i;
        done_d   = grant_q;
      end else if (wd_q == WW'(TIMEOUT - 1)) begin
        state_d  = S_DONE;
        result_d = '0;
        terr_d   = 1'b1;
        done_d   = grant_q;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = '0;
        terr_d  = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      terr_q   <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      wd_q     <= wd_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      terr_q   <= terr_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end
  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign timeout_err_o = terr_q;
  assign busy_o        = busy_q;
  assign eng_start_o   = start_q;
  assign eng_data_o    = data_q;
endmodule
